// File: rtl/gcd_pkg.sv
// gcd_pkg -- shared definitions for the GCD controller slice.
//   GCD_WIDTH   : default operand/result width
//   gcd_state_e : controller state encoding (IDLE / CALC / DONE)
// Optional feature macro used by the slice: GCD_ITER_COUNT_EN.
package gcd_pkg;

    localparam int GCD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/gcd_if.sv
// gcd_if -- request/result bundle between a requester and gcd_controller.
//   start, a_in, b_in        : requester -> controller (operands sampled on accept)
//   ready, busy, done        : controller status (exactly one high at a time)
//   gcd_out                  : result, stable until the next accepted start
//   iter_count               : subtraction count, only with GCD_ITER_COUNT_EN
// Modports: master (requester side), slave (controller side).
interface gcd_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] gcd_out;
`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] iter_count;

    modport master (
        output start, a_in, b_in,
        input  ready, busy, done, gcd_out, iter_count
    );

    modport slave (
        input  start, a_in, b_in,
        output ready, busy, done, gcd_out, iter_count
    );
`else
    modport master (
        output start, a_in, b_in,
        input  ready, busy, done, gcd_out
    );

    modport slave (
        input  start, a_in, b_in,
        output ready, busy, done, gcd_out
    );
`endif

endinterface

// File: rtl/gcd_cmp.sv
// gcd_cmp -- unsigned magnitude comparator.
//   a, b       : WIDTH-bit unsigned operands
//   gt, eq, lt : a>b, a==b, a<b (exactly one is high)
module gcd_cmp
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = ~(eq | gt);

endmodule

// File: rtl/gcd_controller.sv
// gcd_controller -- subtractive (Euclid) GCD engine with a 3-state FSM.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset; aborts any computation
//   bus      : gcd_if.slave -- start/a_in/b_in in; ready/busy/done/gcd_out out
// One subtraction per CALC cycle; latency from accept to done pulse is 2+s
// cycles for s subtractions. Status outputs are registered and move with the
// state so exactly one of ready/busy/done is high.
// Optional feature: define GCD_ITER_COUNT_EN to add bus.iter_count, a
// saturating count of subtractions for the current/last computation.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic  clk,
    input  logic  rst,
    gcd_if.slave  bus
);

    gcd_state_e       state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] gcd_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             any_zero;

`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] iter_q;
`endif

    gcd_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a  (ra),
        .b  (rb),
        .gt (gt),
        .eq (eq),
        .lt (lt)
    );

    // A zero operand terminates immediately: gcd(0,x)=x and gcd(0,0)=0,
    // which ra|rb covers in one expression.
    assign any_zero = (ra == '0) || (rb == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ra      <= '0;
            rb      <= '0;
            gcd_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
            iter_q  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ra      <= bus.a_in;
                        rb      <= bus.b_in;
                        state   <= CALC;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef GCD_ITER_COUNT_EN
                        iter_q  <= '0;
`endif
                    end
                end

                CALC: begin
                    if (any_zero || eq) begin
                        // eq: ra==rb, so ra|rb == ra as well
                        gcd_q  <= ra | rb;
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        // larger operand is always the minuend: no underflow
                        if (gt)
                            ra <= ra - rb;
                        else if (lt)
                            rb <= rb - ra;
`ifdef GCD_ITER_COUNT_EN
                        if (iter_q != '1)
                            iter_q <= iter_q + 1'b1;
`endif
                    end
                end

                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end

                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready   = ready_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.gcd_out = gcd_q;
`ifdef GCD_ITER_COUNT_EN
    assign bus.iter_count = iter_q;
`endif

endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller -- scoreboard bench for gcd_controller (WIDTH=8).
// Expected {gcd, subtraction count} entries are queued when an operation is
// launched and checked (value, latency, iter_count if GCD_ITER_COUNT_EN)
// when done pulses.
module tb_gcd_controller;

    localparam int W = 8;

    typedef struct {
        int g;
        int s;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcd_if #(.WIDTH(W)) bus ();

    gcd_controller #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Reference: Euclid by division. The subtractive algorithm performs
    // sum(quotients)-1 subtractions (the final equal step is not a subtraction).
    function automatic void model(input int a, input int b, output int g, output int s);
        int x, y, r;
        s = 0;
        if (a == 0 || b == 0) begin
            g = a | b;
            return;
        end
        x = (a > b) ? a : b;
        y = (a > b) ? b : a;
        while (y != 0) begin
            s += x / y;
            r = x % y;
            x = y;
            y = r;
        end
        g = x;
        s = s - 1;
    endfunction

    // accept tracking: sampled at the edge, before DUT registers update
    always @(posedge clk) begin
        if (!rst && bus.start && bus.ready)
            acc_cyc = cyc;
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            chk("done_pulse", prev_done, 0);
            chk("onehot_done", {bus.ready, bus.busy}, 0);
            if (sb_q.size() == 0) begin
                chk("sb_empty", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                chk("gcd_out", bus.gcd_out, mon_e.g);
                chk("latency", cyc - acc_cyc, mon_e.s + 2);
`ifdef GCD_ITER_COUNT_EN
                chk("iter_count", bus.iter_count, (mon_e.s > 255) ? 255 : mon_e.s);
`endif
            end
        end
        prev_done = bus.done;
    end

    // Entered and left at a negedge; returns in the first cycle after accept.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int g, input int s, input bit push);
        exp_t e;
        bit   ok;
        e.g = g;
        e.s = s;
        ok  = 1'b0;
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        for (int i = 0; i < 50; i++) begin
            if (bus.ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", bus.ready, 1);
            bus.start = 1'b0;
            return;
        end
        if (push)
            sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = W'($urandom);
        bus.b_in  = W'($urandom);
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.done)
                return;
            @(negedge clk);
        end
        chk("done_timeout", bus.done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tbl_a[4] = '{7, 0, 0, 5};
        int tbl_b[4] = '{7, 5, 0, 0};
        int tbl_g[4] = '{7, 5, 0, 5};
        int g, s, ra_i, rb_i;

        // start held high through reset: reset must win
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a_in  = 8'd12;
        bus.b_in  = 8'd8;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_gcd_out", bus.gcd_out, 0);
`ifdef GCD_ITER_COUNT_EN
        chk("rst_iter", bus.iter_count, 0);
`endif
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_hold", bus.ready, 1);

        // 12,8: register trace (12,8) -> (4,8) -> (4,4)
        run_op(8'd12, 8'd8, 4, 2, 1'b1);
        chk("trace0_ra", dut.ra, 12);
        chk("trace0_rb", dut.rb, 8);
        chk("calc_busy", bus.busy, 1);
        @(negedge clk);
        chk("trace1_ra", dut.ra, 4);
        chk("trace1_rb", dut.rb, 8);
        @(negedge clk);
        chk("trace2_ra", dut.ra, 4);
        chk("trace2_rb", dut.rb, 4);
        wait_done(10);
        @(negedge clk);

        // equal and zero-operand cases
        for (int i = 0; i < 4; i++) begin
            run_op(W'(tbl_a[i]), W'(tbl_b[i]), tbl_g[i], 0, 1'b1);
            wait_done(10);
            @(negedge clk);
        end

        // long run with start pulses during CALC that must be ignored
        run_op(8'd255, 8'd1, 1, 254, 1'b1);
        for (int i = 0; i < 6; i++) begin
            bus.start = 1'b1;
            bus.a_in  = 8'd3;
            bus.b_in  = 8'd3;
            @(negedge clk);
            chk("long_busy", bus.busy, 1);
        end
        bus.start = 1'b0;
        wait_done(300);
        @(negedge clk);

        // abort in the second CALC cycle; gcd_out was 1, must clear
        run_op(8'd12, 8'd8, 4, 2, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("abort_ready", bus.ready, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_gcd_out", bus.gcd_out, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", bus.done, 0);
        end

        // back-to-back: second start held through DONE, taken in the next IDLE
        run_op(8'd9, 8'd6, 3, 2, 1'b1);
        wait_done(20);
        run_op(8'd10, 8'd4, 2, 3, 1'b1);
        wait_done(20);
        @(negedge clk);

        // random operands against the division-based model
        for (int i = 0; i < 6; i++) begin
            ra_i = $urandom_range(0, 255);
            rb_i = $urandom_range(0, 255);
            model(ra_i, rb_i, g, s);
            run_op(W'(ra_i), W'(rb_i), g, s, 1'b1);
            wait_done(300);
            @(negedge clk);
        end

        // result holds in IDLE
        repeat (5) @(negedge clk);
        chk("hold_gcd_out", bus.gcd_out, g);
`ifdef GCD_ITER_COUNT_EN
        chk("hold_iter", bus.iter_count, s);
`endif
        chk("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 Parameter: WIDTH, 8, operand and result bit width (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin a computation; sampled only while ready=1.
REQ-005 a_in  input  WIDTH  first operand; captured when start is accepted.
REQ-006 b_in  input  WIDTH  second operand; captured when start is accepted.
REQ-007 ready  output  1  block is idle and will accept start this cycle.
REQ-008 busy  output  1  computation in progress (state CALC).
REQ-009 done  output  1  single-cycle pulse when gcd_out becomes valid.
REQ-010 gcd_out  output  WIDTH  result; holds its value until the next accepted start.

Function
REQ-011 The state machine SHALL have three states, IDLE, CALC and DONE, with one-hot-equivalent outputs: ready=1 only in IDLE, busy=1 only in CALC, done=1 only in DONE.
REQ-012 IDLE SHALL load a_in/b_in into internal registers ra/rb and move to CALC on a clk edge where start=1; with start=0 it SHALL stay in IDLE.
REQ-013 Each CALC cycle SHALL evaluate the gt/eq/lt comparison of ra and rb and perform at most one update.
- ra==0 or rb==0: gcd_out <= ra|rb, go to DONE.
- eq: gcd_out <= ra, go to DONE.
- gt: ra <= ra-rb, stay in CALC.
- lt: rb <= rb-ra, stay in CALC.
REQ-014 Subtraction SHALL be WIDTH-bit unsigned and never underflows, because the larger operand is always the minuend.
REQ-015 DONE SHALL last exactly one cycle and then return unconditionally to IDLE.
REQ-016 Latency from the accepting edge to the done pulse SHALL be 2+s cycles, where s is the number of subtractions performed.
REQ-017 start SHALL be ignored while busy or done is 1, and operand inputs SHALL be ignored outside the accepting edge.
REQ-018 gcd(0,0) SHALL return 0, and gcd(0,x) and gcd(x,0) SHALL return x, with s=0.
REQ-019 start may be asserted in the IDLE cycle that immediately follows DONE, and SHALL be accepted there (back-to-back operation).

Reset
REQ-020 rst=1 at a clk edge SHALL force state IDLE and ra=rb=gcd_out=0, giving ready=1, busy=0 and done=0.
REQ-021 rst SHALL abort a computation in any state, and no done pulse SHALL follow the abort.
REQ-022 rst SHALL take priority over start on the same edge.

Configuration
REQ-023 Macro GCD_ITER_COUNT_EN SHALL control the iteration counter feature.
- When defined: add output iter_count (WIDTH bits).
  - Cleared on an accepted start.
  - Increments on each subtraction and saturates at all-ones.
  - Holds its value after DONE until the next accepted start.
  - Reset value 0.
- When undefined: the port and its counter logic are absent, and all other behaviour is identical.

Structure
REQ-024 Shared package gcd_pkg SHALL hold the state typedef (IDLE/CALC/DONE) and the default WIDTH constant.
REQ-025 The magnitude comparison SHALL be a sub-module, gcd_cmp, parameterised by WIDTH, with outputs gt, eq and lt (exactly one of which is high), instantiated once in gcd_controller.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- a=12, b=8, start for one cycle -> ra/rb sequence (12,8), (4,8), (4,4); done 4 cycles after acceptance; gcd_out=4; iter_count=2.
- a=7, b=7 -> done 2 cycles after acceptance; gcd_out=7; iter_count=0.
- a=0, b=5 -> gcd_out=5; a=0, b=0 -> gcd_out=0; each with done 2 cycles after acceptance.
- a=255, b=1 (WIDTH=8) -> 254 subtractions; done at cycle 256; gcd_out=1; iter_count=254; start pulses during CALC are ignored.
- a=12, b=8 started, then rst asserted in the second CALC cycle -> next cycle ready=1, gcd_out=0, and no done pulse follows.
- Back-to-back: (9,6) then start held in the following IDLE cycle with (10,4) -> two done pulses, gcd_out=3 then 2.
